tt_sel_seq: RTL and testbench



---
 rtl/tt_sel_seq.sv | 98 +++++++++
 tb/tb_tt_sel_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/tt_sel_seq.sv
// tt_sel_seq: turns a valid/ready design-select request into the chip-top pad sequence
// disable -> selector reset -> N increment pulses -> enable, every phase PULSE_W cycles long.
module tt_sel_seq #(
    parameter int ADDR_W  = 10,
    parameter int PULSE_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_ena,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              ctrl_sel_rst_n,
    output logic              ctrl_sel_inc,
    output logic              ctrl_ena
);
    localparam int CW = $clog2(PULSE_W + 1);

    typedef enum logic [2:0] {IDLE, DIS, RST, REL, INC_H, INC_L, ENA} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] rem_q, rem_d, tgt_q, cur_q;
    logic              ena_q, go_q, ready_q, busy_q, done_q, rstn_q, inc_q, cena_q;
    logic              accept, last, finish;

    // go_q delays the sequence start by one edge after accept; it also blocks a
    // second accept while req_ready still shows the pre-accept idle level.
    always_comb begin
        accept  = req_valid & ready_q & ~go_q & (state_q == IDLE);
        last    = cnt_q == CW'(PULSE_W - 1);
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE:    state_d = go_q ? DIS : IDLE;
            DIS:     state_d = last ? RST : DIS;
            RST:     state_d = last ? REL : RST;
            REL:     state_d = !last ? REL : (rem_q != '0) ? INC_H : ENA;
            INC_H:   state_d = last ? INC_L : INC_H;
            INC_L: begin
                if (last) begin
                    rem_d   = rem_q - 1'b1;
                    state_d = (rem_d != '0) ? INC_H : ENA;
                end
            end
            ENA:     state_d = last ? IDLE : ENA;
            default: state_d = IDLE;
        endcase
        cnt_d  = (state_q == IDLE || state_d != state_q) ? '0 : cnt_q + 1'b1;
        finish = (state_q == ENA) && (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            tgt_q   <= '0;
            cur_q   <= '0;
            ena_q   <= 1'b0;
            go_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rstn_q  <= 1'b0;
            inc_q   <= 1'b0;
            cena_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= accept ? req_addr : rem_d;
            if (accept) begin
                tgt_q <= req_addr;
                ena_q <= req_ena;
            end
            if (finish) cur_q <= tgt_q;
            go_q    <= accept;
            ready_q <= state_d == IDLE;
            busy_q  <= state_d != IDLE;
            done_q  <= finish;
            rstn_q  <= state_d != RST;
            inc_q   <= state_d == INC_H;
            // enable is only driven in ENA and otherwise held through IDLE
            cena_q  <= (state_d == ENA) ? ena_q : (state_d == IDLE) ? cena_q : 1'b0;
        end
    end

    assign req_ready      = ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign cur_addr       = cur_q;
    assign ctrl_sel_rst_n = rstn_q;
    assign ctrl_sel_inc   = inc_q;
    assign ctrl_ena       = cena_q;
endmodule

// File: tb/tb_tt_sel_seq.sv
// tb_tt_sel_seq: directed checks of the design-select pad sequence against hand-computed timing.
module tb_tt_sel_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       rv, re, v6, e6;
    logic [9:0] ra;
    logic [3:0] a6;
    logic       ready, busy, done, srn, inc, ena;
    logic [9:0] cur;
    logic       ready6, busy6, done6, srn6, inc6, ena6;
    logic [3:0] cur6;

    tt_sel_seq #(.ADDR_W(10), .PULSE_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(rv), .req_ready(ready), .req_addr(ra),
        .req_ena(re), .busy(busy), .done(done), .cur_addr(cur),
        .ctrl_sel_rst_n(srn), .ctrl_sel_inc(inc), .ctrl_ena(ena)
    );

    tt_sel_seq #(.ADDR_W(4), .PULSE_W(1)) dut6 (
        .clk(clk), .rst_n(rst_n), .req_valid(v6), .req_ready(ready6), .req_addr(a6),
        .req_ena(e6), .busy(busy6), .done(done6), .cur_addr(cur6),
        .ctrl_sel_rst_n(srn6), .ctrl_sel_inc(inc6), .ctrl_ena(ena6)
    );

    logic sel = 1'b0;
    wire       m_busy  = sel ? busy6 : busy;
    wire       m_done  = sel ? done6 : done;
    wire       m_inc   = sel ? inc6 : inc;
    wire       m_srn   = sel ? srn6 : srn;
    wire       m_ena   = sel ? ena6 : ena;
    wire [9:0] m_cur   = sel ? {6'd0, cur6} : cur;

    int n_chk = 0, n_pass = 0;
    int m_busy_rise, m_busy_cnt, m_inc_pulses, m_inc_first, m_inc_bad;
    int m_rst_first, m_rst_last, m_ena_first, m_done_at, m_cur_done, m_viol;

    // Issue one request on the selected DUT (accept edge = 0) and record pad timing
    // relative to that edge until done, with a fixed cycle budget.
    task automatic measure(input int a, input logic e, input int p);
        int last_rise, last_fall;
        logic pi, pe, pr;
        @(negedge clk);
        if (sel) begin v6 = 1'b1; a6 = a[3:0]; e6 = e; end
        else begin rv = 1'b1; ra = a[9:0]; re = e; end
        @(posedge clk);
        @(negedge clk);
        rv = 1'b0; v6 = 1'b0;
        m_busy_rise = -1; m_busy_cnt = 0; m_inc_pulses = 0; m_inc_first = -1; m_inc_bad = 0;
        m_rst_first = -1; m_rst_last = -1; m_ena_first = -1; m_done_at = -1; m_cur_done = -1;
        m_viol = 0; last_rise = -1; last_fall = -1;
        pi = m_inc; pe = m_ena; pr = m_srn;
        for (int k = 1; k <= 200 && m_done_at < 0; k++) begin
            @(posedge clk);
            #1;
            if (m_busy) begin
                m_busy_cnt++;
                if (m_busy_rise < 0) m_busy_rise = k;
            end
            if (m_inc && !pi) begin
                m_inc_pulses++;
                if (m_inc_first < 0) m_inc_first = k;
                if (last_fall >= 0 && k - last_fall != p) m_inc_bad++;
                last_rise = k;
            end
            if (!m_inc && pi) begin
                if (k - last_rise != p) m_inc_bad++;
                last_fall = k;
            end
            if (!m_srn) begin
                if (m_rst_first < 0) m_rst_first = k;
                m_rst_last = k;
            end
            if (m_ena && m_ena_first < 0) m_ena_first = k;
            if (m_ena !== pe && (m_inc !== pi || m_srn !== pr)) m_viol++;
            if (m_done) begin m_done_at = k; m_cur_done = int'(m_cur); end
            pi = m_inc; pe = m_ena; pr = m_srn;
        end
    endtask

    task automatic test_reset;
        #2;
        n_chk++; if ({ready, busy, done, srn, inc, ena} !== 6'b0) $display("FAIL reset_async_outs: got %b want 000000", {ready, busy, done, srn, inc, ena}); else n_pass++;
        n_chk++; if (cur !== 10'd0) $display("FAIL reset_cur: got %0d want 0", cur); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if ({ready, srn, ready6, srn6} !== 4'b0) $display("FAIL reset_held_over_edge: got %b want 0000", {ready, srn, ready6, srn6}); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_chk++; if ({ready, srn, busy} !== 3'b110) $display("FAIL release_first_edge: got %b want 110", {ready, srn, busy}); else n_pass++;
    endtask

    task automatic test_addr0;
        sel = 1'b0;
        measure(0, 1'b1, 2);
        n_chk++; if (m_busy_rise !== 1) $display("FAIL a0_busy_rise: got %0d want 1", m_busy_rise); else n_pass++;
        n_chk++; if (m_busy_cnt !== 8) $display("FAIL a0_busy_len: got %0d want 8", m_busy_cnt); else n_pass++;
        n_chk++; if (m_inc_pulses !== 0) $display("FAIL a0_inc_pulses: got %0d want 0", m_inc_pulses); else n_pass++;
        n_chk++; if (m_rst_first !== 3 || m_rst_last !== 4) $display("FAIL a0_sel_rst_window: got %0d..%0d want 3..4", m_rst_first, m_rst_last); else n_pass++;
        n_chk++; if (m_ena_first !== 7) $display("FAIL a0_ena_rise: got %0d want 7", m_ena_first); else n_pass++;
        n_chk++; if (m_done_at !== 9) $display("FAIL a0_done_at: got %0d want 9", m_done_at); else n_pass++;
        n_chk++; if (m_cur_done !== 0 || ready !== 1'b1) $display("FAIL a0_cur_ready: got cur %0d ready %b want 0 1", m_cur_done, ready); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if (done !== 1'b0 || ena !== 1'b1) $display("FAIL a0_done_single_ena_hold: got done %b ena %b want 0 1", done, ena); else n_pass++;
    endtask

    task automatic test_addr5;
        measure(5, 1'b1, 2);
        n_chk++; if (m_inc_pulses !== 5) $display("FAIL a5_inc_pulses: got %0d want 5", m_inc_pulses); else n_pass++;
        n_chk++; if (m_inc_bad !== 0) $display("FAIL a5_inc_widths: got %0d bad want 0", m_inc_bad); else n_pass++;
        n_chk++; if (m_inc_first !== 7) $display("FAIL a5_inc_first: got %0d want 7", m_inc_first); else n_pass++;
        n_chk++; if (m_busy_cnt !== 28) $display("FAIL a5_busy_len: got %0d want 28", m_busy_cnt); else n_pass++;
        n_chk++; if (m_ena_first !== 27) $display("FAIL a5_ena_rise: got %0d want 27", m_ena_first); else n_pass++;
        n_chk++; if (m_done_at !== 29) $display("FAIL a5_done_at: got %0d want 29", m_done_at); else n_pass++;
        n_chk++; if (m_cur_done !== 5) $display("FAIL a5_cur: got %0d want 5", m_cur_done); else n_pass++;
        n_chk++; if (m_viol !== 0) $display("FAIL a5_ena_vs_pads: got %0d want 0", m_viol); else n_pass++;
    endtask

    task automatic test_ena0;
        measure(3, 1'b0, 2);
        n_chk++; if (m_inc_pulses !== 3) $display("FAIL e0_inc_pulses: got %0d want 3", m_inc_pulses); else n_pass++;
        n_chk++; if (m_ena_first !== -1) $display("FAIL e0_ena_never: got %0d want -1", m_ena_first); else n_pass++;
        n_chk++; if (m_done_at !== 21) $display("FAIL e0_done_at: got %0d want 21", m_done_at); else n_pass++;
        n_chk++; if (m_cur_done !== 3) $display("FAIL e0_cur: got %0d want 3", m_cur_done); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (ena !== 1'b0 || ready !== 1'b1) $display("FAIL e0_idle_ena: got ena %b ready %b want 0 1", ena, ready); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int d1, d2, early;
        d1 = -1; d2 = -1; early = 0;
        @(negedge clk); rv = 1'b1; ra = 10'd2; re = 1'b1;
        @(posedge clk);
        @(negedge clk); ra = 10'd1;
        for (int k = 1; k <= 60 && d1 < 0; k++) begin
            @(posedge clk); #1;
            if (done) d1 = k;
            else if (ready) early++;
        end
        n_chk++; if (d1 !== 17) $display("FAIL b2b_first_done: got %0d want 17", d1); else n_pass++;
        n_chk++; if (early !== 0) $display("FAIL b2b_not_ready_while_busy: got %0d want 0", early); else n_pass++;
        n_chk++; if (cur !== 10'd2 || ena !== 1'b1) $display("FAIL b2b_first_cur_ena: got cur %0d ena %b want 2 1", cur, ena); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if (ena !== 1'b1 || busy !== 1'b0) $display("FAIL b2b_accept_edge: got ena %b busy %b want 1 0", ena, busy); else n_pass++;
        @(negedge clk); rv = 1'b0;
        @(posedge clk); #1;
        n_chk++; if (ena !== 1'b0 || busy !== 1'b1) $display("FAIL b2b_ena_drop: got ena %b busy %b want 0 1", ena, busy); else n_pass++;
        for (int k = 20; k <= 80 && d2 < 0; k++) begin
            @(posedge clk); #1;
            if (done) d2 = k;
        end
        n_chk++; if (d2 !== 31) $display("FAIL b2b_second_done: got %0d want 31", d2); else n_pass++;
        n_chk++; if (cur !== 10'd1) $display("FAIL b2b_second_cur: got %0d want 1", cur); else n_pass++;
    endtask

    task automatic test_reset_mid;
        @(negedge clk); rv = 1'b1; ra = 10'd10; re = 1'b1;
        @(posedge clk);
        @(negedge clk); rv = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        n_chk++; if (inc !== 1'b1) $display("FAIL rm_in_inc_h: got %b want 1", inc); else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_chk++; if ({inc, srn, ena, busy, ready} !== 5'b0) $display("FAIL rm_async_outs: got %b want 00000", {inc, srn, ena, busy, ready}); else n_pass++;
        n_chk++; if (cur !== 10'd0) $display("FAIL rm_cur_cleared: got %0d want 0", cur); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if (done !== 1'b0 || inc !== 1'b0) $display("FAIL rm_no_done: got done %b inc %b want 0 0", done, inc); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_chk++; if (ready !== 1'b1 || srn !== 1'b1) $display("FAIL rm_release: got ready %b srn %b want 1 1", ready, srn); else n_pass++;
        measure(2, 1'b1, 2);
        n_chk++; if (m_inc_pulses !== 2 || m_busy_cnt !== 16) $display("FAIL rm_rerun_shape: got pulses %0d busy %0d want 2 16", m_inc_pulses, m_busy_cnt); else n_pass++;
        n_chk++; if (m_done_at !== 17 || m_cur_done !== 2) $display("FAIL rm_rerun_done: got at %0d cur %0d want 17 2", m_done_at, m_cur_done); else n_pass++;
    endtask

    task automatic test_pulse1_max;
        sel = 1'b1;
        measure(15, 1'b1, 1);
        n_chk++; if (m_inc_pulses !== 15) $display("FAIL p1_inc_pulses: got %0d want 15", m_inc_pulses); else n_pass++;
        n_chk++; if (m_inc_bad !== 0) $display("FAIL p1_inc_widths: got %0d bad want 0", m_inc_bad); else n_pass++;
        n_chk++; if (m_busy_cnt !== 34) $display("FAIL p1_busy_len: got %0d want 34", m_busy_cnt); else n_pass++;
        n_chk++; if (m_done_at !== 35) $display("FAIL p1_done_at: got %0d want 35", m_done_at); else n_pass++;
        n_chk++; if (m_cur_done !== 15) $display("FAIL p1_cur: got %0d want 15", m_cur_done); else n_pass++;
        sel = 1'b0;
    endtask

    initial begin
        rv = 1'b0; re = 1'b0; ra = '0; v6 = 1'b0; e6 = 1'b0; a6 = '0;
        test_reset();
        test_addr0();
        test_addr5();
        test_ena0();
        test_back_to_back();
        test_reset_mid();
        test_pulse1_max();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
